// File: rtl/strobe_qualifier_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : strobe_qualifier_pkg
//  Description : Shared constants and helpers for the strobe qualifier.
//                Provides the output-mode encodings, the event-counter width
//                and a constant clog2 used to size the per-channel
//                saturating counter and the IDX encoder output.
//  Revision    : 1.0 - initial release
// ============================================================================
package strobe_qualifier_pkg;

    // Output mode encodings for the MODE parameter
    localparam int MODE_LEVEL = 0;
    localparam int MODE_PULSE = 1;

    // Width of each per-channel qualification event counter
    localparam int EVCNT_W = 8;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/strobe_qualifier_ch.sv
`default_nettype none
// ============================================================================
//  Module      : strobe_qualifier_ch
//  Description : One strobe-qualification channel. A saturating counter of
//                consecutive high samples of STBin; the channel output is
//                asserted once DEPTH consecutive highs have been seen (level
//                mode) or for exactly one cycle at that moment (pulse mode).
//                Any low sample clears the count and the output at once.
//  Optional    : STROBE_QUALIFIER_EVCNT_EN adds CLR and an 8-bit wrapping
//                count of qualification events.
//  Ports       : CLK      - system clock (posedge)
//                RST      - synchronous active-high reset
//                STBin    - raw strobe sample
//                STB_next - combinational next value of STB (for the
//                           top-level ANY/IDX encoder)
//                STB      - registered qualified strobe
//                CLR      - clear event counter (macro only)
//                EVCNT    - event counter (macro only)
//  Revision    : 1.0 - initial release
// ============================================================================
module strobe_qualifier_ch
    import strobe_qualifier_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int MODE  = MODE_LEVEL
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               STBin,
`ifdef STROBE_QUALIFIER_EVCNT_EN
    input  logic               CLR,
    output logic [EVCNT_W-1:0] EVCNT,
`endif
    output logic               STB_next,
    output logic               STB
);

    localparam int               CNT_W   = clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;
    logic             r_stb_q;
    logic             w_stb_d;
    logic             w_qual_evt;

    always_comb begin
        w_cnt_d = '0;
        if (STBin) begin
            // Saturate at DEPTH so a long high run never wraps back below it
            w_cnt_d = (r_cnt_q == c_depth) ? r_cnt_q : (r_cnt_q + c_one);
        end
        // The edge on which the count first reaches DEPTH
        w_qual_evt = (w_cnt_d == c_depth) && (r_cnt_q != c_depth);
        if (MODE == MODE_PULSE) begin
            w_stb_d = w_qual_evt;
        end else begin
            w_stb_d = (w_cnt_d == c_depth);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt_q <= '0;
            r_stb_q <= 1'b0;
        end else begin
            r_cnt_q <= w_cnt_d;
            r_stb_q <= w_stb_d;
        end
    end

    // Not gated by RST: the top level resets its own ANY/IDX registers.
    assign STB_next = w_stb_d;
    assign STB      = r_stb_q;

`ifdef STROBE_QUALIFIER_EVCNT_EN
    logic [EVCNT_W-1:0] r_evcnt_q;
    logic [EVCNT_W-1:0] w_evcnt_d;

    always_comb begin
        w_evcnt_d = r_evcnt_q;
        // CLR takes priority over a coincident qualification event
        if (CLR) begin
            w_evcnt_d = '0;
        end else if (w_qual_evt) begin
            w_evcnt_d = r_evcnt_q + EVCNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_evcnt_q <= '0;
        end else begin
            r_evcnt_q <= w_evcnt_d;
        end
    end

    assign EVCNT = r_evcnt_q;
`endif

endmodule
`default_nettype wire

// File: rtl/strobe_qualifier.sv
`default_nettype none
// ============================================================================
//  Module      : strobe_qualifier
//  Description : Multi-channel strobe qualifier. Each channel raises its STB
//                bit after DEPTH consecutive high samples of its STBin bit
//                and drops it on the first low sample. MODE selects level or
//                single-pulse output. ANY and IDX (lowest asserted channel)
//                are computed from the STB next-state vector so that they are
//                registered on the same edge as STB.
//  Optional    : STROBE_QUALIFIER_EVCNT_EN adds CLR and EVCNT (8 bits per
//                channel, channel i at [8i+7:8i]).
//  Ports       : CLK   - system clock (posedge)
//                RST   - synchronous active-high reset
//                STBin - raw strobes, bit i = channel i
//                STB   - registered qualified strobes
//                ANY   - registered OR of STB
//                IDX   - registered lowest asserted STB index, 0 if none
//                CLR   - clear all event counters (macro only)
//                EVCNT - packed event counters (macro only)
//  Revision    : 1.0 - initial release
// ============================================================================
module strobe_qualifier
    import strobe_qualifier_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int DEPTH    = 3,
    parameter  int MODE     = MODE_LEVEL,
    localparam int IDX_W    = (clog2(CHANNELS) > 1) ? clog2(CHANNELS) : 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [CHANNELS-1:0]         STBin,
`ifdef STROBE_QUALIFIER_EVCNT_EN
    input  logic                        CLR,
    output logic [CHANNELS*EVCNT_W-1:0] EVCNT,
`endif
    output logic [CHANNELS-1:0]         STB,
    output logic                        ANY,
    output logic [IDX_W-1:0]            IDX
);

    logic [CHANNELS-1:0] w_stb_next;
    logic                w_any_d;
    logic [IDX_W-1:0]    w_idx_d;
    logic                r_any_q;
    logic [IDX_W-1:0]    r_idx_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        strobe_qualifier_ch #(
            .DEPTH (DEPTH),
            .MODE  (MODE)
        ) u_ch (
            .CLK      (CLK),
            .RST      (RST),
            .STBin    (STBin[g]),
`ifdef STROBE_QUALIFIER_EVCNT_EN
            .CLR      (CLR),
            .EVCNT    (EVCNT[g*EVCNT_W +: EVCNT_W]),
`endif
            .STB_next (w_stb_next[g]),
            .STB      (STB[g])
        );
    end

    // Priority encoder: scanning from the top down lets the lowest set bit
    // overwrite any higher one.
    always_comb begin
        w_any_d = |w_stb_next;
        w_idx_d = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (w_stb_next[i]) begin
                w_idx_d = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_any_q <= 1'b0;
            r_idx_q <= '0;
        end else begin
            r_any_q <= w_any_d;
            r_idx_q <= w_idx_d;
        end
    end

    assign ANY = r_any_q;
    assign IDX = r_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_strobe_qualifier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_strobe_qualifier
//  Description : Self-checking bench for strobe_qualifier. Three instances
//                (DEPTH=3 level, DEPTH=3 pulse, DEPTH=1 level) are driven
//                with directed vectors. A run-length model predicts STB, ANY,
//                IDX (and EVCNT when STROBE_QUALIFIER_EVCNT_EN is defined)
//                and is compared every cycle; literal checks pin key cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_strobe_qualifier;
    import strobe_qualifier_pkg::*;

    localparam int NDUT = 3;
    localparam int NCH  = 4;

    function automatic int dep_of(input int d);
        return (d == 2) ? 1 : 3;
    endfunction

    function automatic int mode_of(input int d);
        return (d == 1) ? MODE_PULSE : MODE_LEVEL;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] in_v  [NDUT];
    logic [3:0] stb_o [NDUT];
    logic       any_o [NDUT];
    logic [1:0] idx_o [NDUT];
`ifdef STROBE_QUALIFIER_EVCNT_EN
    logic        clr;
    logic [31:0] ev_o [NDUT];
`endif

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        strobe_qualifier #(
            .CHANNELS (NCH),
            .DEPTH    (dep_of(g)),
            .MODE     (mode_of(g))
        ) u_dut (
            .CLK   (clk),
            .RST   (rst),
            .STBin (in_v[g]),
`ifdef STROBE_QUALIFIER_EVCNT_EN
            .CLR   (clr),
            .EVCNT (ev_o[g]),
`endif
            .STB   (stb_o[g]),
            .ANY   (any_o[g]),
            .IDX   (idx_o[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut=%0d got=%0h want=%0h t=%0t", nm, d, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: run length of consecutive highs ---
    int         run   [NDUT][NCH];
    logic [3:0] e_stb [NDUT];
    logic       e_any [NDUT];
    logic [1:0] e_idx [NDUT];
`ifdef STROBE_QUALIFIER_EVCNT_EN
    logic [7:0] e_ev  [NDUT][NCH];
`endif

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            e_stb[d] = '0;
            e_any[d] = 1'b0;
            e_idx[d] = '0;
            for (int c = 0; c < NCH; c++) begin
                run[d][c] = 0;
`ifdef STROBE_QUALIFIER_EVCNT_EN
                e_ev[d][c] = '0;
`endif
            end
        end
    end

    always @(posedge clk) begin : model
        int prev;
        bit hit;
        for (int d = 0; d < NDUT; d++) begin
            for (int c = 0; c < NCH; c++) begin
                hit = 1'b0;
                if (rst) begin
                    run[d][c] = 0;
`ifdef STROBE_QUALIFIER_EVCNT_EN
                    e_ev[d][c] = '0;
`endif
                end else begin
                    prev = run[d][c];
                    run[d][c] = in_v[d][c] ? ((prev < 100000) ? prev + 1 : prev) : 0;
                    hit = (run[d][c] == dep_of(d)) && (prev < dep_of(d));
`ifdef STROBE_QUALIFIER_EVCNT_EN
                    if (clr) e_ev[d][c] = '0;
                    else if (hit) e_ev[d][c] = e_ev[d][c] + 8'd1;
`endif
                end
                if (rst) e_stb[d][c] = 1'b0;
                else if (mode_of(d) == MODE_PULSE) e_stb[d][c] = hit;
                else e_stb[d][c] = (run[d][c] >= dep_of(d));
            end
            e_any[d] = |e_stb[d];
            e_idx[d] = '0;
            for (int c = NCH - 1; c >= 0; c--) begin
                if (e_stb[d][c]) e_idx[d] = 2'(c);
            end
        end
    end

    // ---------------- per-cycle compare ------------------------------------
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < NDUT; d++) begin
                check("model_stb", d, 64'(stb_o[d]), 64'(e_stb[d]));
                check("model_any", d, 64'(any_o[d]), 64'(e_any[d]));
                check("model_idx", d, 64'(idx_o[d]), 64'(e_idx[d]));
`ifdef STROBE_QUALIFIER_EVCNT_EN
                for (int c = 0; c < NCH; c++) begin
                    check("model_evcnt", d, 64'(ev_o[d][c*8 +: 8]), 64'(e_ev[d][c]));
                end
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus with literal checks ----------------
    initial begin
        int np, p1, p2;
        logic [5:0] pat;

        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) in_v[d] = '0;
`ifdef STROBE_QUALIFIER_EVCNT_EN
        clr = 1'b0;
`endif
        tick();
        chk_en = 1'b1;
        tick();
        check("reset_stb", 0, 64'(stb_o[0]), 64'h0);
        check("reset_any", 0, 64'(any_o[0]), 64'h0);
        check("reset_idx", 0, 64'(idx_o[0]), 64'h0);
        rst = 1'b0;

        // Legacy timing: 6 highs on channel 0
        in_v[0][0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("legacy_stb0", 0, 64'(stb_o[0][0]), 64'(k >= 3));
            check("legacy_any", 0, 64'(any_o[0]), 64'(k >= 3));
        end
        check("legacy_idx", 0, 64'(idx_o[0]), 64'h0);
        in_v[0][0] = 1'b0;
        tick();
        check("legacy_fall", 0, 64'(stb_o[0][0]), 64'h0);

        // Glitch: 1,1,0,1,1,1 qualifies on the 6th edge
        pat = 6'b111011;
        for (int k = 1; k <= 6; k++) begin
            in_v[0][1] = pat[k-1];
            tick();
            check("glitch_a", 0, 64'(stb_o[0][1]), 64'(k == 6));
        end
        in_v[0][1] = 1'b0;
        tick();
        // 1,1,0,1,1,0 never qualifies
        pat = 6'b011011;
        for (int k = 1; k <= 6; k++) begin
            in_v[0][1] = pat[k-1];
            tick();
            check("glitch_b", 0, 64'(stb_o[0][1]), 64'h0);
        end

        // Pulse mode: 10 high, 1 low, 5 high on channel 2
        np = 0; p1 = 0; p2 = 0;
        for (int e = 1; e <= 16; e++) begin
            in_v[1][2] = (e <= 10 || e >= 12);
            tick();
            if (stb_o[1][2]) begin
                np++;
                if (np == 1) p1 = e;
                else if (np == 2) p2 = e;
            end
        end
        check("pulse_count", 1, 64'(np), 64'd2);
        check("pulse_first", 1, 64'(p1), 64'd3);
        check("pulse_second", 1, 64'(p2), 64'd14);
        in_v[1][2] = 1'b0;
        tick();

        // Priority and reset: channels 3 and 1 together
        in_v[0] = 4'b1010;
        tick();
        tick();
        check("prio_pre", 0, 64'(stb_o[0]), 64'h0);
        tick();
        check("prio_stb", 0, 64'(stb_o[0]), 64'hA);
        check("prio_any", 0, 64'(any_o[0]), 64'h1);
        check("prio_idx", 0, 64'(idx_o[0]), 64'h1);
        rst = 1'b1;
        tick();
        check("rst_stb", 0, 64'(stb_o[0]), 64'h0);
        check("rst_any", 0, 64'(any_o[0]), 64'h0);
        check("rst_idx", 0, 64'(idx_o[0]), 64'h0);
        rst = 1'b0;
        tick();
        tick();
        check("requal_pre", 0, 64'(stb_o[0]), 64'h0);
        tick();
        check("requal_stb", 0, 64'(stb_o[0]), 64'hA);
        check("requal_idx", 0, 64'(idx_o[0]), 64'h1);
        in_v[0] = '0;
        tick();

        // DEPTH=1: STB follows STBin one edge later; other DUTs get noise
        for (int k = 0; k < 100; k++) begin
            in_v[0] = 4'($urandom);
            in_v[1] = 4'($urandom);
            in_v[2] = 4'($urandom);
            tick();
            check("d1_follow", 2, 64'(stb_o[2]), 64'(in_v[2]));
        end
        for (int d = 0; d < NDUT; d++) in_v[d] = '0;
        tick();

`ifdef STROBE_QUALIFIER_EVCNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        // one qualification on channel 1 of the pulse DUT
        in_v[1][1] = 1'b1;
        repeat (3) tick();
        in_v[1][1] = 1'b0;
        tick();
        // 257 qualifications on channel 0
        for (int q = 0; q < 257; q++) begin
            in_v[1][0] = 1'b1;
            repeat (3) tick();
            in_v[1][0] = 1'b0;
            tick();
        end
        check("evcnt_wrap_ch0", 1, 64'(ev_o[1][7:0]), 64'd1);
        check("evcnt_ch1", 1, 64'(ev_o[1][15:8]), 64'd1);
        check("evcnt_ch2", 1, 64'(ev_o[1][23:16]), 64'd0);
        // CLR coincident with the qualifying edge
        in_v[1][0] = 1'b1;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_pulse", 1, 64'(stb_o[1][0]), 64'h1);
        check("clr_wins", 1, 64'(ev_o[1][7:0]), 64'd0);
        in_v[1][0] = 1'b0;
        tick();
`endif

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
